// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO with fill count, programmable almost flags, synchronous flush
// and either registered-read or first-word-fall-through output.
module fifo_sync_param #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 4,
    parameter int FWFT      = 0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic [WIDTH-1:0]             wdata_i,
    input  logic                         wr_en_i,
    input  logic                         rd_en_i,
    output logic [WIDTH-1:0]             r_data_o,
    output logic                         rd_valid_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic                         almost_full_o,
    output logic                         almost_empty_o,
    output logic [$clog2(DEPTH):0]       count_o,
    output logic                         wr_error_o,
    output logic                         rd_error_o
);

    localparam int PTR_WIDTH = $clog2(DEPTH);
    localparam int CW        = PTR_WIDTH + 1;

    localparam logic [CW-1:0]        DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0]        AF_C     = CW'(AF_THRESH);
    localparam logic [CW-1:0]        AE_C     = CW'(AE_THRESH);
    localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(DEPTH - 1);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [CW-1:0]        count_q;
    logic [CW-1:0]        count_next;
    logic                 full_q;
    logic                 empty_q;
    logic                 af_q;
    logic                 ae_q;
    logic                 wr_err_q;
    logic                 rd_err_q;
    logic                 rd_acc;
    logic                 wr_acc;
    logic [WIDTH-1:0]     head;

    // Explicit wrap so non-power-of-2 depths index only valid entries.
    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign head = mem[rd_ptr];

    // A full FIFO may still accept a write when a read frees a slot on the same edge;
    // an empty FIFO never lets a same-edge write satisfy a read.
    always_comb begin
        rd_acc     = rd_en_i && !empty_q;
        wr_acc     = wr_en_i && (!full_q || rd_acc);
        count_next = count_q;
        if (wr_acc && !rd_acc) begin
            count_next = count_q + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_next = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            wr_err_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else if (flush_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            wr_err_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_acc) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count_q  <= count_next;
            full_q   <= (count_next == DEPTH_C);
            empty_q  <= (count_next == '0);
            af_q     <= (count_next >= AF_C);
            ae_q     <= (count_next <= AE_C);
            wr_err_q <= wr_en_i && !wr_acc;
            rd_err_q <= rd_en_i && !rd_acc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && !flush_i && wr_acc) begin
            mem[wr_ptr] <= wdata_i;
        end
    end

    generate
        if (FWFT == 0) begin : g_std
            logic [WIDTH-1:0] r_data_q;
            logic             rd_valid_q;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_data_q   <= '0;
                    rd_valid_q <= 1'b0;
                end else if (flush_i) begin
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc) begin
                        r_data_q <= head;
                    end
                end
            end

            assign r_data_o   = r_data_q;
            assign rd_valid_o = rd_valid_q;
        end else begin : g_fwft
            // Remembers the word last shown so the output holds steady while empty.
            logic [WIDTH-1:0] r_data_q;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_data_q <= '0;
                end else if (!empty_q) begin
                    r_data_q <= head;
                end
            end

            assign r_data_o   = empty_q ? r_data_q : head;
            assign rd_valid_o = !empty_q;
        end
    endgenerate

    assign full_o         = full_q;
    assign empty_o        = empty_q;
    assign almost_full_o  = af_q;
    assign almost_empty_o = ae_q;
    assign count_o        = count_q;
    assign wr_error_o     = wr_err_q;
    assign rd_error_o     = rd_err_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: three instances (standard depth 16, FWFT depth 16, standard depth 5)
// share one stimulus stream and are compared each cycle against queue-based reference models.
module tb_fifo_sync_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] wdata;

    logic [7:0] rd0, rd1, rd2;
    logic [2:0] valid, full, empty, af, ae, werr, rerr;
    logic [4:0] cnt0, cnt1;
    logic [3:0] cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_sync_param #(.WIDTH(8), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(4), .FWFT(0)) u_std (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .wdata_i(wdata), .wr_en_i(wr_en), .rd_en_i(rd_en),
        .r_data_o(rd0), .rd_valid_o(valid[0]), .full_o(full[0]), .empty_o(empty[0]),
        .almost_full_o(af[0]), .almost_empty_o(ae[0]), .count_o(cnt0),
        .wr_error_o(werr[0]), .rd_error_o(rerr[0]));

    fifo_sync_param #(.WIDTH(8), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(4), .FWFT(1)) u_fwft (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .wdata_i(wdata), .wr_en_i(wr_en), .rd_en_i(rd_en),
        .r_data_o(rd1), .rd_valid_o(valid[1]), .full_o(full[1]), .empty_o(empty[1]),
        .almost_full_o(af[1]), .almost_empty_o(ae[1]), .count_o(cnt1),
        .wr_error_o(werr[1]), .rd_error_o(rerr[1]));

    fifo_sync_param #(.WIDTH(8), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1), .FWFT(0)) u_d5 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .wdata_i(wdata), .wr_en_i(wr_en), .rd_en_i(rd_en),
        .r_data_o(rd2), .rd_valid_o(valid[2]), .full_o(full[2]), .empty_o(empty[2]),
        .almost_full_o(af[2]), .almost_empty_o(ae[2]), .count_o(cnt2),
        .wr_error_o(werr[2]), .rd_error_o(rerr[2]));

    // Reference model: one queue per instance plus the expected registered outputs.
    int         dep [3] = '{16, 16, 5};
    int         afth[3] = '{12, 12, 4};
    int         aeth[3] = '{4, 4, 1};
    bit         fw  [3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0] mq  [3][$];
    logic [7:0] e_rdata[3];
    bit         e_valid[3];
    bit         e_werr [3];
    bit         e_rerr [3];

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mq[i].delete();
            e_rdata[i] = 8'h00;
            e_valid[i] = 1'b0;
            e_werr[i]  = 1'b0;
            e_rerr[i]  = 1'b0;
        end
    endtask

    task automatic model_step(input bit w, input bit r, input bit f, input logic [7:0] d);
        for (int i = 0; i < 3; i++) begin
            if (f) begin
                mq[i].delete();
                e_werr[i]  = 1'b0;
                e_rerr[i]  = 1'b0;
                e_valid[i] = 1'b0;
            end else begin
                int  n   = mq[i].size();
                bit  rok = r && (n > 0);
                bit  wok = w && ((n < dep[i]) || rok);
                e_werr[i] = w && !wok;
                e_rerr[i] = r && !rok;
                if (!fw[i]) e_valid[i] = rok;
                if (rok) begin
                    logic [7:0] popped = mq[i].pop_front();
                    if (!fw[i]) e_rdata[i] = popped;
                end
                if (wok) mq[i].push_back(d);
            end
            if (fw[i]) begin
                e_valid[i] = (mq[i].size() > 0);
                if (mq[i].size() > 0) e_rdata[i] = mq[i][0];
            end
        end
    endtask

    task automatic chk(input int i, input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL u%0d %s observed %0h expected %0h", i, tag, got, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            int         n = mq[i].size();
            logic [7:0] g_rd;
            logic [4:0] g_cnt;
            case (i)
                0:       begin g_rd = rd0; g_cnt = cnt0;         end
                1:       begin g_rd = rd1; g_cnt = cnt1;         end
                default: begin g_rd = rd2; g_cnt = {1'b0, cnt2}; end
            endcase
            chk(i, "count",    32'(g_cnt), 32'(n));
            chk(i, "full",     32'(full[i]),  32'(n == dep[i]));
            chk(i, "empty",    32'(empty[i]), 32'(n == 0));
            chk(i, "afull",    32'(af[i]),    32'(n >= afth[i]));
            chk(i, "aempty",   32'(ae[i]),    32'(n <= aeth[i]));
            chk(i, "wr_err",   32'(werr[i]),  32'(e_werr[i]));
            chk(i, "rd_err",   32'(rerr[i]),  32'(e_rerr[i]));
            chk(i, "rd_valid", 32'(valid[i]), 32'(e_valid[i]));
            chk(i, "r_data",   32'(g_rd),     32'(e_rdata[i]));
        end
    endtask

    // Drive at the falling edge, let the rising edge act, compare 1 time unit later.
    task automatic cycle(input bit w, input bit r, input bit f, input logic [7:0] d);
        wr_en = w;
        rd_en = r;
        flush = f;
        wdata = d;
        @(posedge clk);
        model_step(w, r, f, d);
        #1;
        check_all();
        @(negedge clk);
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        wdata = 8'h00;
        model_reset();
        @(negedge clk);
        check_all();
        rst = 1'b0;

        // Fill with 0x01..0x10, then one write too many.
        for (int k = 1; k <= 16; k++) cycle(1'b1, 1'b0, 1'b0, 8'(k));
        cycle(1'b1, 1'b0, 1'b0, 8'h11);

        // Drain in order, then one read too many.
        for (int k = 0; k < 17; k++) cycle(1'b0, 1'b1, 1'b0, 8'h00);

        // Full FIFO with simultaneous read and write of 0xAA.
        for (int k = 0; k < 16; k++) cycle(1'b1, 1'b0, 1'b0, 8'($urandom));
        cycle(1'b1, 1'b1, 1'b0, 8'hAA);
        for (int k = 0; k < 16; k++) cycle(1'b0, 1'b1, 1'b0, 8'h00);

        // Empty FIFO with simultaneous read and write of 0x55.
        cycle(1'b1, 1'b1, 1'b0, 8'h55);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 8'h00);

        // Random interleaved traffic; the depth-5 instance wraps its pointers many times.
        for (int k = 0; k < 80; k++) begin
            cycle($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
                  $urandom_range(0, 99) < 3, 8'($urandom));
        end

        // Flush at count 7 with a write request present.
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        for (int k = 0; k < 7; k++) cycle(1'b1, 1'b0, 1'b0, 8'($urandom));
        cycle(1'b1, 1'b1, 1'b1, 8'($urandom));
        for (int k = 0; k < 12; k++) cycle(k % 3 != 2, k % 3 != 0, 1'b0, 8'($urandom));

        // Asynchronous reset in the middle of a write burst.
        for (int k = 0; k < 5; k++) cycle(1'b1, k[0], 1'b0, 8'($urandom));
        wr_en = 1'b1;
        wdata = 8'($urandom);
        @(posedge clk);
        model_step(1'b1, 1'b0, 1'b0, wdata);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst   = 1'b0;
        wr_en = 1'b0;
        cycle(1'b1, 1'b0, 1'b0, 8'h3C);
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
